// File: rtl/rt_access_ctrl_if.sv
// Request/response channel between a requester (master) and the racetrack access controller (slave).
interface rt_access_ctrl_if #(
   parameter int unsigned AW = 5,
   parameter int unsigned W  = 32
) ();
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_we_i;
   logic [AW-1:0] req_addr_i;
   logic [W-1:0]  req_wdata_i;
   logic [W-1:0]  req_wmask_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [W-1:0]  rsp_rdata_o;

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o
   );
endinterface

// File: rtl/rt_access_ctrl.sv
// Racetrack access controller: aligns the track to the request's port offset with shift
// pulses, then performs a one-cycle write or a READ_LAT-cycle read, and returns a response.
module rt_access_ctrl #(
   parameter int unsigned Nb       = 32,
   parameter int unsigned Np       = 8,
   parameter int unsigned Nr       = 4,
   parameter int unsigned NMU      = 8,
   parameter int unsigned READ_LAT = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   rt_access_ctrl_if.slave   bus,
   output logic              current_s_data_o,
   output logic              current_m_data_o,
   output logic              current_read_o,
   output logic [Nb-1:0]     word_lines_o,
   output logic              out_select_o,
   input  logic [Nr*NMU-1:0] r_data_i,
   output logic [Nr*NMU-1:0] write_data_o,
   output logic [Nr*NMU-1:0] write_mask_o,
   output logic              write_en_data_o,
   output logic              write_en_mask_o
);

   localparam int unsigned W  = Nr * NMU;
   localparam int unsigned Ns = Nb / Np;
   localparam int unsigned AW = (Nb > 1) ? $clog2(Nb) : 1;
   localparam int unsigned SW = (Ns > 1) ? $clog2(Ns) : 1;
   localparam int unsigned CW = $clog2(READ_LAT + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      WRITE = 3'd2,
      READ  = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t        state;
   logic [SW-1:0] off;
   logic [SW-1:0] lat_tgt;
   logic          lat_we;
   logic [AW-1:0] lat_addr;
   logic [W-1:0]  lat_wdata;
   logic [W-1:0]  lat_wmask;
   logic [CW-1:0] cnt;

   logic          req_ready;
   logic          rsp_valid;
   logic [W-1:0]  rsp_rdata;

   logic [AW-1:0] addr_wrap_c;
   logic [SW-1:0] tgt_new_c;
   logic          hs_c;
   logic [SW-1:0] off_step_c;
   logic          enter_access_c;
   logic          acc_we_c;
   logic [AW-1:0] acc_addr_c;
   logic [W-1:0]  acc_wdata_c;
   logic [W-1:0]  acc_wmask_c;

   assign bus.req_ready_o = req_ready;
   assign bus.rsp_valid_o = rsp_valid;
   assign bus.rsp_rdata_o = rsp_rdata;

   function automatic logic [Nb-1:0] onehot(input logic [AW-1:0] a);
      logic [Nb-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

   // Fold out-of-range addresses back into the track (only reachable for non-power-of-2 Nb).
   always_comb begin
      addr_wrap_c = bus.req_addr_i;
      if (32'(bus.req_addr_i) >= Nb) addr_wrap_c = AW'(32'(bus.req_addr_i) - Nb);
   end

   assign tgt_new_c  = addr_wrap_c[SW-1:0];
   assign hs_c       = (state == IDLE) && bus.req_valid_i && req_ready;
   assign off_step_c = current_s_data_o ? (off + SW'(1)) : (off - SW'(1));

   // Access parameters come straight from the bus when no shift is needed, else from the latch.
   always_comb begin
      acc_we_c       = lat_we;
      acc_addr_c     = lat_addr;
      acc_wdata_c    = lat_wdata;
      acc_wmask_c    = lat_wmask;
      enter_access_c = 1'b0;
      if (state == IDLE) begin
         acc_we_c       = bus.req_we_i;
         acc_addr_c     = addr_wrap_c;
         acc_wdata_c    = bus.req_wdata_i;
         acc_wmask_c    = bus.req_wmask_i;
         enter_access_c = hs_c && (tgt_new_c == off);
      end else if (state == SHIFT) begin
         enter_access_c = (off_step_c == lat_tgt);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state            <= IDLE;
         off              <= '0;
         lat_tgt          <= '0;
         lat_we           <= 1'b0;
         lat_addr         <= '0;
         lat_wdata        <= '0;
         lat_wmask        <= '0;
         cnt              <= '0;
         req_ready        <= 1'b0;
         rsp_valid        <= 1'b0;
         rsp_rdata        <= '0;
         current_s_data_o <= 1'b0;
         current_m_data_o <= 1'b0;
         current_read_o   <= 1'b0;
         word_lines_o     <= '0;
         out_select_o     <= 1'b0;
         write_data_o     <= '0;
         write_mask_o     <= '0;
         write_en_data_o  <= 1'b0;
         write_en_mask_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (hs_c) begin
                  req_ready <= 1'b0;
                  lat_tgt   <= tgt_new_c;
                  lat_we    <= bus.req_we_i;
                  lat_addr  <= addr_wrap_c;
                  lat_wdata <= bus.req_wdata_i;
                  lat_wmask <= bus.req_wmask_i;
                  if (tgt_new_c != off) begin
                     state            <= SHIFT;
                     current_s_data_o <= (tgt_new_c > off);
                     current_m_data_o <= (tgt_new_c < off);
                  end
               end
            end
            // One pulse per cycle; the pulse direction register doubles as the shift direction.
            SHIFT: begin
               off <= off_step_c;
               if (off_step_c == lat_tgt) begin
                  current_s_data_o <= 1'b0;
                  current_m_data_o <= 1'b0;
               end
            end
            WRITE: begin
               word_lines_o    <= '0;
               write_data_o    <= '0;
               write_mask_o    <= '0;
               write_en_data_o <= 1'b0;
               write_en_mask_o <= 1'b0;
               rsp_rdata       <= '0;
               rsp_valid       <= 1'b1;
               state           <= RESP;
            end
            READ: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(READ_LAT - 1)) begin
                  word_lines_o   <= '0;
                  current_read_o <= 1'b0;
                  rsp_rdata      <= r_data_i;
                  rsp_valid      <= 1'b1;
                  state          <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (enter_access_c) begin
            word_lines_o <= onehot(acc_addr_c);
            if (acc_we_c) begin
               state           <= WRITE;
               write_data_o    <= acc_wdata_c;
               write_mask_o    <= acc_wmask_c;
               write_en_data_o <= 1'b1;
               write_en_mask_o <= 1'b1;
            end else begin
               state          <= READ;
               cnt            <= '0;
               current_read_o <= 1'b1;
               out_select_o   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rt_access_ctrl.sv
// Directed bench for rt_access_ctrl: shift alignment, write/read sequencing, stalls and reset abort.
module tb_rt_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cur_s, cur_m, cur_rd, out_sel;
   logic [31:0] wl;
   logic [31:0] r_data;
   logic [31:0] wdata_o, wmask_o;
   logic        wen_d, wen_m;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] held;

   rt_access_ctrl_if #(.AW(5), .W(32)) bus ();

   rt_access_ctrl dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .bus              (bus),
      .current_s_data_o (cur_s),
      .current_m_data_o (cur_m),
      .current_read_o   (cur_rd),
      .word_lines_o     (wl),
      .out_select_o     (out_sel),
      .r_data_i         (r_data),
      .write_data_o     (wdata_o),
      .write_mask_o     (wmask_o),
      .write_en_data_o  (wen_d),
      .write_en_mask_o  (wen_m)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_track(input string tag);
      chk({tag, "_s"},  64'(cur_s),  64'd0);
      chk({tag, "_m"},  64'(cur_m),  64'd0);
      chk({tag, "_rd"}, 64'(cur_rd), 64'd0);
      chk({tag, "_wl"}, 64'(wl),     64'd0);
      chk({tag, "_we"}, 64'({wen_d, wen_m}), 64'd0);
      chk({tag, "_wd"}, 64'({wdata_o, wmask_o}), 64'd0);
   endtask

   task automatic drive_req(input logic we, input logic [4:0] addr, input logic [31:0] d, input logic [31:0] m);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = d;
      bus.req_wmask_i = m;
   endtask

   task automatic drop_req();
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b1;
      bus.req_addr_i  = 5'd31;
      bus.req_wdata_i = 32'hFFFF_0000;
      bus.req_wmask_i = 32'h0F0F_0F0F;
   endtask

   initial begin
      rst             = 1'b1;
      r_data          = '0;
      bus.rsp_ready_i = 1'b0;
      drop_req();

      // Reset state
      step(); step();
      chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
      chk("rst_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("rst_rdata", 64'(bus.rsp_rdata_o), 64'd0);
      chk_idle_track("rst");
      rst = 1'b0;
      step();
      chk("post_rst_ready", 64'(bus.req_ready_o), 64'd1);

      // Write addr 0, no shift
      bus.rsp_ready_i = 1'b1;
      drive_req(1'b1, 5'd0, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
      step();
      drop_req();
      chk("w0_wl", 64'(wl), 64'h1);
      chk("w0_en", 64'({wen_d, wen_m}), 64'h3);
      chk("w0_data", 64'(wdata_o), 64'hA5A5_A5A5);
      chk("w0_mask", 64'(wmask_o), 64'hFFFF_FFFF);
      chk("w0_noshift", 64'({cur_s, cur_m}), 64'd0);
      chk("w0_ready", 64'(bus.req_ready_o), 64'd0);
      chk("w0_valid_early", 64'(bus.rsp_valid_o), 64'd0);
      step();
      chk("w0_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("w0_rdata", 64'(bus.rsp_rdata_o), 64'd0);
      chk_idle_track("w0_after");
      step();
      chk("w0_done_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("w0_done_ready", 64'(bus.req_ready_o), 64'd1);

      // Read addr 7: three up-shifts from offset 0
      drive_req(1'b0, 5'd7, 32'h0, 32'h0);
      step();
      drop_req();
      for (int i = 0; i < 3; i++) begin
         chk("r7_pulse", 64'({cur_s, cur_m}), 64'h2);
         step();
      end
      chk("r7_pulse_end", 64'({cur_s, cur_m}), 64'd0);
      chk("r7_rd1", 64'(cur_rd), 64'd1);
      chk("r7_wl", 64'(wl), 64'h80);
      chk("r7_sel", 64'(out_sel), 64'd0);
      r_data = 32'h1111_1111;
      step();
      chk("r7_rd2", 64'(cur_rd), 64'd1);
      chk("r7_valid_early", 64'(bus.rsp_valid_o), 64'd0);
      r_data = 32'hCAFE_F00D;
      step();
      r_data = 32'h0;
      chk("r7_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("r7_rdata", 64'(bus.rsp_rdata_o), 64'hCAFE_F00D);
      chk_idle_track("r7_after");
      step();
      chk("r7_done_ready", 64'(bus.req_ready_o), 64'd1);

      // Read addr 9 (target 1) from offset 3, then stall the response
      bus.rsp_ready_i = 1'b0;
      drive_req(1'b0, 5'd9, 32'h0, 32'h0);
      step();
      drop_req();
      for (int i = 0; i < 2; i++) begin
         chk("r9_pulse", 64'({cur_s, cur_m}), 64'h1);
         step();
      end
      chk("r9_pulse_end", 64'({cur_s, cur_m}), 64'd0);
      chk("r9_wl", 64'(wl), 64'h200);
      r_data = 32'h0;
      step();
      r_data = 32'h1234_5678;
      step();
      r_data = 32'h0;
      chk("r9_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("r9_rdata", 64'(bus.rsp_rdata_o), 64'h1234_5678);
      drive_req(1'b1, 5'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
         step();
         held = bus.rsp_rdata_o;
         chk("stall_valid", 64'(bus.rsp_valid_o), 64'd1);
         chk("stall_rdata", 64'(held), 64'h1234_5678);
         chk("stall_ready", 64'(bus.req_ready_o), 64'd0);
         chk("stall_no_write", 64'({wen_d, wen_m, cur_s, cur_m}), 64'd0);
      end
      drop_req();
      bus.rsp_ready_i = 1'b1;
      step();
      chk("stall_release_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("stall_release_ready", 64'(bus.req_ready_o), 64'd1);
      step();
      chk_idle_track("stall_ignored");

      // Read addr 3 from offset 1, reset on the second pulse
      drive_req(1'b0, 5'd3, 32'h0, 32'h0);
      step();
      drop_req();
      chk("abort_p1", 64'({cur_s, cur_m}), 64'h2);
      step();
      chk("abort_p2", 64'({cur_s, cur_m}), 64'h2);
      rst = 1'b1;
      step();
      chk_idle_track("abort");
      chk("abort_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("abort_ready", 64'(bus.req_ready_o), 64'd0);
      rst = 1'b0;
      step();
      chk("abort_after_ready", 64'(bus.req_ready_o), 64'd1);
      chk("abort_after_valid", 64'(bus.rsp_valid_o), 64'd0);

      // Back-to-back writes to addr 4 and 8: offset must be back at 0, so no shifts
      drive_req(1'b1, 5'd4, 32'h0000_0044, 32'h0000_00FF);
      step();
      drop_req();
      chk("w4_noshift", 64'({cur_s, cur_m}), 64'd0);
      chk("w4_wl", 64'(wl), 64'h10);
      chk("w4_data", 64'({wdata_o, wmask_o}), 64'h0000_0044_0000_00FF);
      step();
      chk("w4_valid", 64'(bus.rsp_valid_o), 64'd1);
      step();
      chk("w4_ready", 64'(bus.req_ready_o), 64'd1);
      drive_req(1'b1, 5'd8, 32'h8888_0000, 32'hFFFF_0000);
      step();
      drop_req();
      chk("w8_noshift", 64'({cur_s, cur_m}), 64'd0);
      chk("w8_wl", 64'(wl), 64'h100);
      chk("w8_en", 64'({wen_d, wen_m}), 64'h3);
      chk("w8_data", 64'({wdata_o, wmask_o}), 64'h8888_0000_FFFF_0000);
      step();
      chk("w8_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("w8_rdata", 64'(bus.rsp_rdata_o), 64'd0);
      step();
      chk("w8_done", 64'({bus.rsp_valid_o, bus.req_ready_o}), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
